// File: rtl/control_unit_fsm_pkg.sv
// Shared encodings for the microcontroller instruction sequencer:
// opcodes, ALU selects, accumulator sources and the FSM state encoding.
package control_unit_fsm_pkg;

   localparam int unsigned OPCODE_WIDTH  = 4;
   localparam int unsigned ALU_OP_WIDTH  = 3;
   localparam int unsigned ACC_SRC_WIDTH = 2;
   localparam int unsigned STATE_WIDTH   = 3;

   localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'h0;
   localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 4'h1;
   localparam logic [OPCODE_WIDTH-1:0] OP_STA = 4'h2;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'h3;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'h4;
   localparam logic [OPCODE_WIDTH-1:0] OP_AND = 4'h5;
   localparam logic [OPCODE_WIDTH-1:0] OP_OR  = 4'h6;
   localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 4'h7;
   localparam logic [OPCODE_WIDTH-1:0] OP_LDI = 4'h8;
   localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'h9;
   localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 4'hA;
   localparam logic [OPCODE_WIDTH-1:0] OP_JNZ = 4'hB;
   localparam logic [OPCODE_WIDTH-1:0] OP_NOT = 4'hC;
   localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'hF;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD    = 3'b000;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB    = 3'b001;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_AND    = 3'b010;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OR     = 3'b011;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR    = 3'b100;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_NOT    = 3'b101;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_PASS_B = 3'b110;

   localparam logic [ACC_SRC_WIDTH-1:0] ACC_SRC_ALU = 2'b00;
   localparam logic [ACC_SRC_WIDTH-1:0] ACC_SRC_RAM = 2'b01;
   localparam logic [ACC_SRC_WIDTH-1:0] ACC_SRC_IMM = 2'b10;

   typedef enum logic [STATE_WIDTH-1:0] {
      ST_FETCH_HI = 3'd0,
      ST_FETCH_LO = 3'd1,
      ST_DECODE   = 3'd2,
      ST_EXECUTE  = 3'd3,
      ST_MEM_WB   = 3'd4,
      ST_HALT     = 3'd5
   } state_t;

   // Opcodes whose result comes back from RAM a cycle after EXECUTE.
   function automatic logic needs_mem_wb(input logic [OPCODE_WIDTH-1:0] op);
      return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
             (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
   endfunction

   function automatic logic [ALU_OP_WIDTH-1:0] alu_for_op(input logic [OPCODE_WIDTH-1:0] op);
      case (op)
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_XOR:  return ALU_XOR;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/control_unit_fsm_decoder.sv
// Combinational strobe decode from sequencer state, opcode and zero flag.
module control_unit_fsm_decoder
   import control_unit_fsm_pkg::*;
(
   input  logic [STATE_WIDTH-1:0]   state,
   input  logic [OPCODE_WIDTH-1:0]  opcode,
   input  logic                     z_flag,
   output logic                     pc_inc,
   output logic                     pc_write_enable,
   output logic                     ir_high_write_enable,
   output logic                     ir_low_write_enable,
   output logic                     acc_write_enable,
   output logic                     z_flag_write_enable,
   output logic [ACC_SRC_WIDTH-1:0] acc_src_sel,
   output logic [ALU_OP_WIDTH-1:0]  alu_op,
   output logic                     ram_write_enable,
   output logic                     halted
);

   always_comb begin
      pc_inc               = 1'b0;
      pc_write_enable      = 1'b0;
      ir_high_write_enable = 1'b0;
      ir_low_write_enable  = 1'b0;
      acc_write_enable     = 1'b0;
      z_flag_write_enable  = 1'b0;
      acc_src_sel          = ACC_SRC_ALU;
      alu_op               = ALU_ADD;
      ram_write_enable     = 1'b0;
      halted               = 1'b0;

      case (state)
         ST_FETCH_HI: begin
            ir_high_write_enable = 1'b1;
            pc_inc               = 1'b1;
         end
         ST_FETCH_LO: begin
            ir_low_write_enable = 1'b1;
            pc_inc              = 1'b1;
         end
         ST_EXECUTE: begin
            case (opcode)
               OP_LDI: begin
                  acc_write_enable    = 1'b1;
                  z_flag_write_enable = 1'b1;
                  acc_src_sel         = ACC_SRC_IMM;
                  alu_op              = ALU_PASS_B;
               end
               OP_NOT: begin
                  acc_write_enable    = 1'b1;
                  z_flag_write_enable = 1'b1;
                  alu_op              = ALU_NOT;
               end
               OP_STA: ram_write_enable = 1'b1;
               OP_JMP: pc_write_enable  = 1'b1;
               OP_JZ:  pc_write_enable  = z_flag;
               OP_JNZ: pc_write_enable  = ~z_flag;
               default: ;
            endcase
         end
         // RAM read data is valid now; LDA takes it directly, ALU ops combine it.
         ST_MEM_WB: begin
            acc_write_enable    = 1'b1;
            z_flag_write_enable = 1'b1;
            if (opcode == OP_LDA) begin
               acc_src_sel = ACC_SRC_RAM;
            end else begin
               alu_op = alu_for_op(opcode);
            end
         end
         ST_HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit_fsm.sv
// Multi-cycle instruction sequencer: state register, next-state logic and
// reset gating of the decoded strobes.
module control_unit_fsm
   import control_unit_fsm_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [OPCODE_WIDTH-1:0]  opcode_in,
   input  logic                     z_flag_in,
   output logic                     pc_inc,
   output logic                     pc_write_enable,
   output logic                     ir_high_write_enable,
   output logic                     ir_low_write_enable,
   output logic                     acc_write_enable,
   output logic                     z_flag_write_enable,
   output logic [ACC_SRC_WIDTH-1:0] acc_src_sel,
   output logic [ALU_OP_WIDTH-1:0]  alu_op,
   output logic                     ram_write_enable,
   output logic                     halted
);

   state_t state_q;
   state_t state_d;

   logic                     dec_pc_inc;
   logic                     dec_pc_we;
   logic                     dec_ir_hi_we;
   logic                     dec_ir_lo_we;
   logic                     dec_acc_we;
   logic                     dec_z_we;
   logic [ACC_SRC_WIDTH-1:0] dec_acc_src;
   logic [ALU_OP_WIDTH-1:0]  dec_alu_op;
   logic                     dec_ram_we;
   logic                     dec_halted;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH_HI;
      end else begin
         state_q <= state_d;
      end
   end

   // Unused encodings fall through to the default and restart the fetch.
   always_comb begin
      state_d = ST_FETCH_HI;
      case (state_q)
         ST_FETCH_HI: state_d = ST_FETCH_LO;
         ST_FETCH_LO: state_d = ST_DECODE;
         ST_DECODE:   state_d = (opcode_in == OP_HLT) ? ST_HALT : ST_EXECUTE;
         ST_EXECUTE:  state_d = needs_mem_wb(opcode_in) ? ST_MEM_WB : ST_FETCH_HI;
         ST_MEM_WB:   state_d = ST_FETCH_HI;
         ST_HALT:     state_d = ST_HALT;
         default:     state_d = ST_FETCH_HI;
      endcase
   end

   control_unit_fsm_decoder u_decoder (
      .state                (state_q),
      .opcode               (opcode_in),
      .z_flag               (z_flag_in),
      .pc_inc               (dec_pc_inc),
      .pc_write_enable      (dec_pc_we),
      .ir_high_write_enable (dec_ir_hi_we),
      .ir_low_write_enable  (dec_ir_lo_we),
      .acc_write_enable     (dec_acc_we),
      .z_flag_write_enable  (dec_z_we),
      .acc_src_sel          (dec_acc_src),
      .alu_op               (dec_alu_op),
      .ram_write_enable     (dec_ram_we),
      .halted               (dec_halted)
   );

   // Reset is synchronous, so the strobes are masked directly to kill any
   // partial instruction in the reset cycle itself.
   always_comb begin
      pc_inc               = dec_pc_inc   & ~reset;
      pc_write_enable      = dec_pc_we    & ~reset;
      ir_high_write_enable = dec_ir_hi_we & ~reset;
      ir_low_write_enable  = dec_ir_lo_we & ~reset;
      acc_write_enable     = dec_acc_we   & ~reset;
      z_flag_write_enable  = dec_z_we     & ~reset;
      acc_src_sel          = reset ? ACC_SRC_ALU : dec_acc_src;
      alu_op               = reset ? ALU_ADD     : dec_alu_op;
      ram_write_enable     = dec_ram_we   & ~reset;
      halted               = dec_halted   & ~reset;
   end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Self-checking bench for control_unit_fsm: directed instruction sequences
// with literal expectations, then randomized opcodes, flags and resets.
module tb_control_unit_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] opcode_in;
   logic       z_flag_in;
   logic       pc_inc, pc_write_enable, ir_high_write_enable, ir_low_write_enable;
   logic       acc_write_enable, z_flag_write_enable, ram_write_enable, halted;
   logic [1:0] acc_src_sel;
   logic [2:0] alu_op;

   control_unit_fsm dut (
      .clk                  (clk),
      .reset                (reset),
      .opcode_in            (opcode_in),
      .z_flag_in            (z_flag_in),
      .pc_inc               (pc_inc),
      .pc_write_enable      (pc_write_enable),
      .ir_high_write_enable (ir_high_write_enable),
      .ir_low_write_enable  (ir_low_write_enable),
      .acc_write_enable     (acc_write_enable),
      .z_flag_write_enable  (z_flag_write_enable),
      .acc_src_sel          (acc_src_sel),
      .alu_op               (alu_op),
      .ram_write_enable     (ram_write_enable),
      .halted               (halted)
   );

   always #5 clk = ~clk;

   // Output vector: {pc_inc, pc_we, ir_hi, ir_lo, acc_we, z_we, src[1:0], alu[2:0], ram_we, halted}
   localparam logic [12:0] V_PC_INC = 13'h1000;
   localparam logic [12:0] V_PC_WE  = 13'h0800;
   localparam logic [12:0] V_IR_HI  = 13'h0400;
   localparam logic [12:0] V_IR_LO  = 13'h0200;
   localparam logic [12:0] V_ACC_WE = 13'h0100;
   localparam logic [12:0] V_Z_WE   = 13'h0080;
   localparam logic [12:0] V_RAM_WE = 13'h0002;
   localparam logic [12:0] V_HALT   = 13'h0001;
   localparam logic [12:0] V_FH     = V_PC_INC | V_IR_HI;
   localparam logic [12:0] V_FL     = V_PC_INC | V_IR_LO;
   localparam logic [12:0] V_LDI    = V_ACC_WE | V_Z_WE | 13'h0040 | 13'h0018;
   localparam logic [12:0] V_SUB_WB = V_ACC_WE | V_Z_WE | 13'h0004;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          m_step  = 1;
   logic [3:0]  m_op    = 4'h0;
   logic [12:0] obs;
   logic [12:0] hist [0:7];

   function automatic int instr_len(input logic [3:0] op);
      return (op == 4'h1 || (op >= 4'h3 && op <= 4'h7)) ? 5 : 4;
   endfunction

   // Expected outputs from the cycle index within the current instruction.
   function automatic logic [12:0] model_out(input int step, input logic [3:0] op,
                                             input logic z, input logic r);
      logic [12:0] v;
      v = 13'h0;
      if (r) return v;
      if (step == 1) return V_FH;
      if (step == 2) return V_FL;
      if (step == 3) return v;
      if (op == 4'hF) return V_HALT;
      if (step == 4) begin
         case (op)
            4'h2: v = V_RAM_WE;
            4'h8: v = V_LDI;
            4'hC: v = V_ACC_WE | V_Z_WE | 13'(5 << 2);
            4'h9: v = V_PC_WE;
            4'hA: v = z ? V_PC_WE : 13'h0;
            4'hB: v = z ? 13'h0 : V_PC_WE;
            default: v = 13'h0;
         endcase
      end else if (op == 4'h1) begin
         v = V_ACC_WE | V_Z_WE | 13'(1 << 5);
      end else begin
         v = V_ACC_WE | V_Z_WE | 13'((int'(op) - 3) << 2);
      end
      return v;
   endfunction

   task automatic check_lit(input string name, input logic [12:0] got, input logic [12:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One clock: drive inputs, compare against the model, advance the model.
   task automatic step_cycle(input logic r, input logic z, input logic [3:0] op_next);
      logic [12:0] exp;
      reset     = r;
      z_flag_in = z;
      #1;
      exp = model_out(m_step, m_op, z, r);
      obs = {pc_inc, pc_write_enable, ir_high_write_enable, ir_low_write_enable,
             acc_write_enable, z_flag_write_enable, acc_src_sel, alu_op,
             ram_write_enable, halted};
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL model t=%0t step=%0d op=%h z=%0b rst=%0b: got %h expected %h",
                  $time, m_step, m_op, z, r, obs, exp);
      end
      @(posedge clk);
      if (r) m_step = 1;
      else if (m_op == 4'hF && m_step >= 4) m_step = 4;
      else if (m_step == instr_len(m_op)) m_step = 1;
      else begin
         if (m_step == 1) m_op = op_next;
         m_step++;
      end
      #1;
      opcode_in = m_op;
   endtask

   task automatic run_instr(input logic [3:0] op, input logic z, input int n);
      for (int i = 0; i < n; i++) begin
         step_cycle(1'b0, z, op);
         hist[i] = obs;
      end
   endtask

   initial begin
      reset     = 1'b1;
      opcode_in = 4'h0;
      z_flag_in = 1'b0;

      for (int i = 0; i < 3; i++) begin
         step_cycle(1'b1, 1'b0, 4'h0);
         check_lit("reset_outputs_zero", obs, 13'h0);
      end

      run_instr(4'h8, 1'b0, 4);
      check_lit("ldi_fetch_hi", hist[0], V_FH);
      check_lit("ldi_fetch_lo", hist[1], V_FL);
      check_lit("ldi_decode", hist[2], 13'h0);
      check_lit("ldi_execute", hist[3], V_LDI);

      run_instr(4'h4, 1'b1, 5);
      check_lit("ldi_then_fetch_hi", hist[0], V_FH);
      check_lit("sub_execute_idle", hist[3], 13'h0);
      check_lit("sub_mem_wb", hist[4], V_SUB_WB);

      run_instr(4'hA, 1'b1, 4);
      check_lit("jz_taken", hist[3], V_PC_WE);
      run_instr(4'hA, 1'b0, 4);
      check_lit("jz_not_taken", hist[3], 13'h0);
      run_instr(4'hB, 1'b1, 4);
      check_lit("jnz_not_taken", hist[3], 13'h0);
      run_instr(4'hB, 1'b0, 4);
      check_lit("jnz_taken", hist[3], V_PC_WE);

      run_instr(4'h1, 1'b0, 4);
      check_lit("lda_execute_idle", hist[3], 13'h0);
      step_cycle(1'b1, 1'b0, 4'h0);
      check_lit("reset_in_mem_wb", obs, 13'h0);
      run_instr(4'h0, 1'b0, 4);
      check_lit("post_reset_fetch_hi", hist[0], V_FH);

      run_instr(4'hF, 1'b0, 3);
      for (int i = 0; i < 20; i++) begin
         step_cycle(1'b0, 1'($urandom_range(1)), 4'($urandom_range(15)));
         check_lit("halted_hold", obs, V_HALT);
      end
      step_cycle(1'b1, 1'b0, 4'h0);
      check_lit("halt_reset_clears", obs, 13'h0);
      run_instr(4'h3, 1'b0, 5);
      check_lit("halt_restart_fetch", hist[0], V_FH);

      for (int i = 0; i < 3000; i++) begin
         logic r;
         r = ($urandom_range(63) == 0) || (m_op == 4'hF && m_step >= 4 && $urandom_range(7) == 0);
         step_cycle(r, 1'($urandom_range(1)), 4'($urandom_range(15)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
